// File: rtl/max_track.sv
// Windowed running-maximum tracker: scans WIN unsigned samples, then presents the largest one.
// Optional macro MAX_TRACK_IDX_EN adds the position register behind max_idx.
module max_track #(
  parameter  int W   = 8,
  parameter  int WIN = 16,
  localparam int CW  = $clog2(WIN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  max_out,
  output logic [CW-1:0] max_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t        r_state;
  // One extra bit so the count can sit at WIN once the window is full.
  logic [CW:0]   r_cnt;
  logic [W-1:0]  r_max;
  logic          w_last;
  logic          w_gt;

  assign w_last = (r_cnt == (CW+1)'(WIN - 1));
  assign w_gt   = (in_data > r_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_max   <= '0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_max   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (in_valid) begin
          r_max   <= in_data;
          r_cnt   <= (CW+1)'(1);
          r_state <= S_ACC;
        end
        S_ACC: if (in_valid) begin
          r_cnt <= r_cnt + (CW+1)'(1);
          if (w_gt) r_max <= in_data;
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MAX_TRACK_IDX_EN
  logic [CW-1:0] r_idx;

  // Strict compare keeps the earliest position on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_idx <= '0;
    end else if (r_state == S_ACC && in_valid && w_gt) begin
      r_idx <= r_cnt[CW-1:0];
    end
  end

  assign max_idx = r_idx;
`else
  assign max_idx = '0;
`endif

  assign in_ready  = (r_state != S_DONE);
  assign out_valid = (r_state == S_DONE);
  assign max_out   = r_max;

endmodule

// File: tb/tb_max_track.sv
// Directed bench for max_track (W=8, WIN=4) with a window-contents reference model.
module tb_max_track;
  localparam int W   = 8;
  localparam int WIN = 4;
  localparam int CW  = $clog2(WIN);

  logic          clk = 1'b0;
  logic          reset;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  max_out;
  logic [CW-1:0] max_idx;

  int total = 0;
  int bad   = 0;

`ifdef MAX_TRACK_IDX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  max_track #(.W(W), .WIN(WIN)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid),
    .max_out(max_out), .max_idx(max_idx)
  );

  always #5 clk = ~clk;

  // Reference: remember the accepted samples of the current window verbatim.
  int m_q [WIN];
  int m_n;
  bit m_done;

  always @(posedge clk or posedge reset) begin
    if (reset || clr) begin
      m_n    <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done <= 1'b0;
        m_n    <= 0;
      end
    end else if (in_valid) begin
      m_q[m_n] <= int'(in_data);
      m_n      <= m_n + 1;
      m_done   <= (m_n + 1 == WIN);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int win_max();
    int mx = m_q[0];
    for (int i = 1; i < WIN; i++) if (m_q[i] > mx) mx = m_q[i];
    return mx;
  endfunction

  function automatic int win_pos();
    int mx = win_max();
    if (!IDX_EN) return 0;
    for (int i = 0; i < WIN; i++) if (m_q[i] == mx) return i;
    return 0;
  endfunction

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("model_out_valid", int'(out_valid), int'(m_done));
      check("model_in_ready", int'(in_ready), int'(!m_done));
      if (m_done) begin
        check("model_max_out", int'(max_out), win_max());
        check("model_max_idx", int'(max_idx), win_pos());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = W'(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input int mx, input int pos);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_max"}, int'(max_out), mx);
    check({name, "_idx"}, int'(max_idx), IDX_EN ? pos : 0);
  endtask

  initial begin
    reset = 1'b1;
    #1;
    check("reset_valid", int'(out_valid), 0);
    check("reset_ready", int'(in_ready), 1);
    check("reset_max", int'(max_out), 0);
    check("reset_idx", int'(max_idx), 0);
    #11;
    reset = 1'b0;
    tick();
    cmp_en = 1'b1;

    // Basic window, consumer always ready: one-cycle pulse.
    out_ready = 1'b1;
    send(3); send(9); send(2);
    check("w1_not_early", int'(out_valid), 0);
    send(7);
    expect_result("w1", 9, 1);
    tick();
    check("w1_pulse_end", int'(out_valid), 0);

    // Ties keep the earliest position; no bubble before this window.
    send(5); send(5); send(1); send(5);
    expect_result("w2_tie", 5, 0);
    tick();

    // Backpressure: result held, new samples refused.
    out_ready = 1'b0;
    send(0); send(0); send(0); send(255);
    in_valid = 1'b1;
    in_data  = 8'd200;
    for (int i = 0; i < 10; i++) begin
      expect_result("w3_hold", 255, 3);
      check("w3_hold_ready", int'(in_ready), 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("w3_release_valid", int'(out_valid), 0);
    check("w3_release_ready", int'(in_ready), 1);

    // clr beats the third accept.
    send(10); send(20);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd30;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    check("clr_valid", int'(out_valid), 0);
    check("clr_ready", int'(in_ready), 1);
    check("clr_max", int'(max_out), 0);
    check("clr_idx", int'(max_idx), 0);
    send(1); send(2); send(3); send(4);
    expect_result("w4", 4, 3);
    tick();

    // clr beats out_ready while DONE.
    out_ready = 1'b0;
    send(6); send(8); send(6); send(1);
    expect_result("w5", 8, 1);
    clr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_done_valid", int'(out_valid), 0);
    check("clr_done_max", int'(max_out), 0);

    // Asynchronous reset mid-window, between edges.
    send(50); send(60);
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", int'(out_valid), 0);
    check("areset_ready", int'(in_ready), 1);
    check("areset_max", int'(max_out), 0);
    check("areset_idx", int'(max_idx), 0);
    #3;
    reset = 1'b0;
    tick();
    send(8); send(1); send(9);
    check("post_reset_not_early", int'(out_valid), 0);
    send(2);
    expect_result("w6", 9, 2);
    tick();
    check("w6_pulse_end", int'(out_valid), 0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
